// File: rtl/inc_burst_gen_pkg.sv
// Shared constants for the inc/clr burst generator that drives the Adder counter.
// State encodings are plain localparams so legacy decode logic can compare against them.
package inc_burst_gen_pkg;

    localparam int WIDTH_DEF    = 8;
    localparam int PERIOD_W_DEF = 16;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_CLEAR = 3'd1;
    localparam state_t ST_RUN   = 3'd2;
    localparam state_t ST_WAIT  = 3'd3;
    localparam state_t ST_DONE  = 3'd4;

endpackage

// File: rtl/burst_gen_timer.sv
// Load/decrement down-counter that times the idle gap between inc pulses.
// expire is high for the single cycle in which the count sits at 1 while enabled.
module burst_gen_timer #(
    parameter int PERIOD_W = 16
) (
    input  logic                aclk,
    input  logic                srst,
    input  logic                load,
    input  logic                en,
    input  logic [PERIOD_W-1:0] load_val,
    output logic                expire
);

    logic [PERIOD_W-1:0] count;

    // NOTE: reset is synchronous, so srst lives inside the clocked branch rather than the sensitivity list.
    always_ff @(posedge aclk) begin
        if (srst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && count != '0) begin
            // NOTE: non-blocking assignment keeps every register update in this edge race-free.
            count <= count - PERIOD_W'(1);
        end
    end

    assign expire = en && (count == PERIOD_W'(1));

endmodule

// File: rtl/inc_burst_gen.sv
// Burst generator: one clr pulse, N inc pulses spaced by P idle cycles, then a done pulse.
// Define INC_BURST_GEN_CNT_EN to add the issued output mirroring the downstream counter value.
module inc_burst_gen
    import inc_burst_gen_pkg::*;
#(
    parameter int WIDTH    = WIDTH_DEF,
    parameter int PERIOD_W = PERIOD_W_DEF
) (
    input  logic                aclk,
    input  logic                srst,
    input  logic                start,
    input  logic                abort,
    input  logic [WIDTH-1:0]    cfg_len,
    input  logic [PERIOD_W-1:0] cfg_period,
    output logic                clr,
    output logic                inc,
    output logic                busy,
    output logic                done
`ifdef INC_BURST_GEN_CNT_EN
    ,
    output logic [WIDTH-1:0]    issued
`endif
);

    state_t              state, state_nxt;
    logic [WIDTH-1:0]    remaining, rem_nxt;
    logic [PERIOD_W-1:0] period_q, period_nxt;
    logic                timer_load;
    logic                timer_expire;

    burst_gen_timer #(
        .PERIOD_W (PERIOD_W)
    ) u_timer (
        .aclk     (aclk),
        .srst     (srst),
        .load     (timer_load),
        .en       (state == ST_WAIT),
        .load_val (period_q),
        .expire   (timer_expire)
    );

    always_comb begin
        // NOTE: every variable gets a default first so no path through the case infers a latch.
        state_nxt  = state;
        rem_nxt    = remaining;
        period_nxt = period_q;
        timer_load = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_nxt  = ST_CLEAR;
                    rem_nxt    = cfg_len;
                    period_nxt = cfg_period;
                end
            end
            ST_CLEAR: begin
                if (abort)                state_nxt = ST_IDLE;
                else if (remaining == '0) state_nxt = ST_DONE;
                else                      state_nxt = ST_RUN;
            end
            ST_RUN: begin
                // Saturating decrement: remaining is never below 1 here, but must not wrap if it were.
                rem_nxt = (remaining != '0) ? remaining - WIDTH'(1) : '0;
                if (abort) begin
                    state_nxt = ST_IDLE;
                end else if (rem_nxt == '0) begin
                    state_nxt = ST_DONE;
                end else if (period_q != '0) begin
                    state_nxt  = ST_WAIT;
                    timer_load = 1'b1;
                end
            end
            ST_WAIT: begin
                if (abort)             state_nxt = ST_IDLE;
                else if (timer_expire) state_nxt = ST_RUN;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (srst) begin
            state     <= ST_IDLE;
            remaining <= '0;
            period_q  <= '0;
        end else begin
            state     <= state_nxt;
            remaining <= rem_nxt;
            period_q  <= period_nxt;
        end
    end

    // Moore decode: outputs depend only on the registered state.
    assign clr  = (state == ST_CLEAR);
    assign inc  = (state == ST_RUN);
    assign busy = (state == ST_CLEAR) || (state == ST_RUN) || (state == ST_WAIT);
    assign done = (state == ST_DONE);

`ifdef INC_BURST_GEN_CNT_EN
    always_ff @(posedge aclk) begin
        if (srst)                 issued <= '0;
        else if (state == ST_CLEAR) issued <= '0;
        else if (state == ST_RUN)   issued <= issued + WIDTH'(1);
    end
`endif

endmodule

// File: tb/tb_inc_burst_gen.sv
// Table-driven bench for inc_burst_gen: each record is one burst with its interruptions and final count.
module tb_inc_burst_gen;

    logic        aclk = 1'b0;
    logic        srst;
    logic        start;
    logic        abort;
    logic [7:0]  cfg_len;
    logic [15:0] cfg_period;
    logic        clr, inc, busy, done;
`ifdef INC_BURST_GEN_CNT_EN
    logic [7:0]  issued;
`endif

    int total  = 0;
    int passed = 0;
    int cnt    = 0;  // model of the downstream Adder counter, sharing srst

    typedef struct {
        int len;
        int period;
        int abort_at;
        int restart_at;
        int srst_at;
        int exp_cnt;
    } vec_t;

    vec_t vecs[11];

    inc_burst_gen #(.WIDTH(8), .PERIOD_W(16)) dut (
        .aclk       (aclk),
        .srst       (srst),
        .start      (start),
        .abort      (abort),
        .cfg_len    (cfg_len),
        .cfg_period (cfg_period),
        .clr        (clr),
        .inc        (inc),
        .busy       (busy),
        .done       (done)
`ifdef INC_BURST_GEN_CNT_EN
        ,
        .issued     (issued)
`endif
    );

    always #5 aclk = ~aclk;

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    // Start at cycle 0, then compare {clr,inc,busy,done} every cycle against the timing formulas.
    task automatic run_burst(input vec_t v, input int idx);
        int n;
        int p;
        int stop;
        int done_c;
        int last;
        bit active;
        logic [3:0] exp_o;
        n      = v.len;
        p      = v.period;
        stop   = (v.abort_at >= 0) ? v.abort_at : v.srst_at;
        done_c = (n == 0) ? 2 : 3 + (n - 1) * (p + 1);
        last   = (stop >= 0 && stop < done_c) ? stop + 3 : done_c + 2;
        @(posedge aclk); #1;
        start      = 1'b1;
        abort      = 1'b0;
        cfg_len    = 8'(n);
        cfg_period = 16'(p);
        for (int c = 1; c <= last; c++) begin
            @(posedge aclk); #1;
            start = 1'b0;
            abort = (c == v.abort_at);
            srst  = (c == v.srst_at);
            if (c == v.restart_at) begin
                start      = 1'b1;
                cfg_len    = 8'd50;
                cfg_period = 16'd0;
            end
            active   = (stop < 0) || (c <= stop);
            exp_o[3] = active && (c == 1);
            exp_o[2] = active && (c >= 2) && ((c - 2) % (p + 1) == 0) && ((c - 2) / (p + 1) < n);
            exp_o[1] = active && (c >= 1) && (c < done_c);
            exp_o[0] = active && (c == done_c);
            check($sformatf("v%0d_c%0d_clr_inc_busy_done", idx, c),
                  int'({clr, inc, busy, done}), int'(exp_o));
            if (clr)      cnt = 0;
            else if (inc) cnt = (cnt + 1) % 256;
            if (srst)     cnt = 0;
        end
        start = 1'b0;
        abort = 1'b0;
        srst  = 1'b0;
        check($sformatf("v%0d_adder_out", idx), cnt, v.exp_cnt);
`ifdef INC_BURST_GEN_CNT_EN
        check($sformatf("v%0d_issued", idx), int'(issued), v.exp_cnt);
`endif
    endtask

    initial begin
        //          len  P    abort restart srst exp_cnt
        vecs[0]  = '{3,   0,   -1,   -1,    -1,  3};
        vecs[1]  = '{4,   2,   -1,   -1,    -1,  4};
        vecs[2]  = '{0,   5,   -1,   -1,    -1,  0};
        vecs[3]  = '{10,  1,    6,   -1,    -1,  3};
        vecs[4]  = '{5,   0,   -1,    3,    -1,  5};
        vecs[5]  = '{4,   2,   -1,   -1,     4,  0};
        vecs[6]  = '{6,   3,   -1,   -1,    -1,  6};
        vecs[7]  = '{5,   4,    1,   -1,    -1,  0};
        vecs[8]  = '{4,   2,    3,   -1,    -1,  1};
        vecs[9]  = '{255, 0,   -1,   -1,    -1,  255};
        vecs[10] = '{2,   300, -1,   -1,    -1,  2};

        srst       = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        cfg_len    = '0;
        cfg_period = '0;
        repeat (3) @(posedge aclk);
        #1;
        check("reset_outputs", int'({clr, inc, busy, done}), 0);
`ifdef INC_BURST_GEN_CNT_EN
        check("reset_issued", int'(issued), 0);
`endif
        srst = 1'b0;

        // start and abort together in IDLE: abort wins, nothing happens.
        @(posedge aclk); #1;
        start   = 1'b1;
        abort   = 1'b1;
        cfg_len = 8'd3;
        for (int c = 1; c <= 3; c++) begin
            @(posedge aclk); #1;
            start = 1'b0;
            abort = 1'b0;
            check($sformatf("start_abort_idle_c%0d", c), int'({clr, inc, busy, done}), 0);
        end

        for (int i = 0; i < 11; i++) run_burst(vecs[i], i);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/inc_burst_gen.md
Name: inc_burst_gen

Overview:
Upstream stimulus stage for the Adder counter. On a start strobe it issues one clr pulse, then a programmable burst of N single-cycle inc pulses spaced by P idle cycles, then a done pulse. Its clr/inc outputs drive the counter's clr/inc inputs directly. At the end of an unaborted burst the counter holds N.

Parameters:
WIDTH, 8, width of the burst-length config; matches the counter WIDTH.
PERIOD_W, 16, width of the inter-pulse gap config.

Ports:
aclk  input  1  clock, rising edge.
srst  input  1  synchronous reset, active-high.
start  input  1  burst request strobe; sampled only in IDLE.
abort  input  1  terminates an active burst.
cfg_len  input  WIDTH  N = number of inc pulses; latched on accepted start.
cfg_period  input  PERIOD_W  P = idle cycles between inc pulses; latched on accepted start.
clr  output  1  counter clear pulse.
inc  output  1  counter increment pulse.
busy  output  1  burst in progress.
done  output  1  one-cycle completion pulse.

Behaviour:
- Reset: srst=1 at a rising edge -> state IDLE; clr=inc=busy=done=0; internal remaining/timer=0. Valid mid-burst; no done is issued.
- Outputs are Moore-decoded from the registered state, with no input-to-output combinational path.
- States and decoded outputs:
  - IDLE: all outputs 0.
  - CLEAR: clr=1, busy=1.
  - RUN: inc=1, busy=1.
  - WAIT: busy=1.
  - DONE: done=1, busy=0.
- Transitions:
  - IDLE: start=1 and abort=0 -> CLEAR; latch remaining=cfg_len, period=cfg_period. Otherwise stay IDLE.
  - CLEAR: remaining==0 -> DONE; else -> RUN.
  - RUN: remaining decrements by 1 each RUN cycle. Then:
    - new remaining==0 -> DONE;
    - else if P==0 -> stay RUN;
    - else -> WAIT with timer=P.
  - WAIT: timer decrements each cycle; timer==1 -> RUN.
  - DONE -> IDLE unconditionally.
- Timing, with start accepted at cycle 0:
  - clr at cycle 1.
  - inc at cycles 2 + k(P+1), for k=0..N-1.
  - done at cycle 3 + (N-1)(P+1).
  - N=0: done at cycle 2, no inc.
- abort=1 in CLEAR, RUN or WAIT -> IDLE at the next edge. No done is issued. An inc or clr already asserted in the abort cycle still counts.
- abort has priority over start when both are high in IDLE.
- start while busy or in DONE is ignored; cfg_* changes after latch are ignored.
- Arithmetic:
  - remaining and timer are unsigned and never wrap below 0.
  - N max = 2^WIDTH-1, which fits the downstream counter without overflow.
  - P max = 2^PERIOD_W-1.

Optional Feature:
Macro INC_BURST_GEN_CNT_EN.
- Defined: adds output issued [WIDTH-1:0].
  - Reset to 0; cleared in CLEAR.
  - Increments in every RUN cycle; holds through DONE/IDLE and after abort.
  - Mirrors the expected counter value for self-checking.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Package inc_burst_gen_pkg: state enum (IDLE, CLEAR, RUN, WAIT, DONE), default WIDTH/PERIOD_W localparams.
- One sub-module, burst_gen_timer:
  - PERIOD_W-wide load/decrement down-counter, with a single-cycle expire flag when the count equals 1.
  - Used for WAIT; the FSM and the remaining counter stay in the top level.

Test Plan:
- N=3, P=0, start at cycle 0 -> clr@1, inc@2,3,4, done@5; downstream Adder out=3; busy high cycles 1-4.
- N=4, P=2 -> inc@2,5,8,11, done@12; Adder out=4.
- N=0, P=5 -> clr@1, done@2, no inc; Adder out=0.
- N=10, P=1, abort at cycle 6 (RUN, third inc) -> that inc counts, IDLE next cycle, no done; Adder out=3; start+abort together in IDLE -> stays IDLE.
- start pulsed again during a burst with cfg_len changed to 50 -> ignored; burst completes with original N.
- srst asserted mid-WAIT -> all outputs 0 next cycle, IDLE; a fresh start then runs a full burst. With INC_BURST_GEN_CNT_EN, issued tracks the Adder out in every scenario.
